// File: rtl/lif_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lif_pkg: shared word format and config-loader state type.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef LIF_PKG_SV
`define LIF_PKG_SV

`define W 16
// Q-format literal with 8 fractional bits, truncated toward zero.
`define FX(x) (`W'($rtoi((x) * 256.0)))

package lif_pkg;

  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_LOAD_D = 2'd2,
    S_DONE   = 2'd3
  } snn_cfg_state_t;

endpackage

`endif
`default_nettype wire

// File: rtl/snn_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snn_cfg_loader: streams weights then delays into a layer cfg port. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module snn_cfg_loader
  import lif_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_NEURONS = 2,
  parameter int MAX_DELAY   = 8,
  localparam int NSYN   = NUM_NEURONS * NUM_INPUTS,
  localparam int ADDR_W = (NSYN > 2) ? $clog2(NSYN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [`W-1:0]     s_data,
  output logic              cfg_we,
  output logic              cfg_sel_delay,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [`W-1:0]     cfg_wdata,
  output logic [7:0]        cfg_delay,
  output logic              busy,
  output logic              done,
  output logic              clamp_err
);

  localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(NSYN - 1);
  localparam logic [`W-1:0]     c_MAX_D_W   = `W'(MAX_DELAY - 1);
  localparam logic [7:0]        c_MAX_D_8   = 8'(MAX_DELAY - 1);

  snn_cfg_state_t    r_state;
  snn_cfg_state_t    w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_ready;
  logic              r_we;
  logic              r_sel_delay;
  logic [ADDR_W-1:0] r_addr;
  logic [`W-1:0]     r_wdata;
  logic [7:0]        r_delay;
  logic              r_done;
  logic              r_clamp_err;

  logic              w_hs;
  logic              w_last;
  logic              w_load;
  logic              w_over;
  logic [7:0]        w_delay_clamped;

  // Abort masks ready so a word offered in the abort cycle is never consumed.
  assign s_ready         = r_ready & ~abort;
  assign w_hs            = s_valid & s_ready;
  assign w_last          = (r_idx == c_LAST_IDX);
  assign w_load          = (r_state == S_LOAD_W) || (r_state == S_LOAD_D);
  assign w_over          = (s_data > c_MAX_D_W);
  assign w_delay_clamped = w_over ? c_MAX_D_8 : s_data[7:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && !abort) w_state_nxt = S_LOAD_W;
      S_LOAD_W: begin
        if (abort)              w_state_nxt = S_IDLE;
        else if (w_hs && w_last) w_state_nxt = S_LOAD_D;
      end
      S_LOAD_D: begin
        if (abort)              w_state_nxt = S_IDLE;
        else if (w_hs && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_sel_delay <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_delay     <= '0;
      r_done      <= 1'b0;
      r_clamp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_LOAD_W) || (w_state_nxt == S_LOAD_D);
      r_we    <= w_hs;
      r_done  <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE && start && !abort) begin
        r_idx       <= '0;
        r_clamp_err <= 1'b0;
      end else if (abort && w_load) begin
        r_idx <= '0;
      end else if (w_hs) begin
        r_idx       <= w_last ? '0 : r_idx + 1'b1;
        r_addr      <= r_idx;
        r_sel_delay <= (r_state == S_LOAD_D);
        if (r_state == S_LOAD_D) begin
          r_delay <= w_delay_clamped;
          if (w_over) r_clamp_err <= 1'b1;
        end else begin
          r_wdata <= s_data;
        end
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign cfg_we        = r_we;
  assign cfg_sel_delay = r_sel_delay;
  assign cfg_addr      = r_addr;
  assign cfg_wdata     = r_wdata;
  assign cfg_delay     = r_delay;
  assign clamp_err     = r_clamp_err;

endmodule
`default_nettype wire

// File: tb/tb_snn_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_snn_cfg_loader: scoreboard bench with a transaction-level model.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_snn_cfg_loader;
  import lif_pkg::*;

  localparam int NI   = 2;
  localparam int NN   = 2;
  localparam int MD   = 8;
  localparam int NSYN = NI * NN;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [`W-1:0] s_data = '0;
  logic          cfg_we;
  logic          cfg_sel_delay;
  logic [AW-1:0] cfg_addr;
  logic [`W-1:0] cfg_wdata;
  logic [7:0]    cfg_delay;
  logic          busy;
  logic          done;
  logic          clamp_err;

  snn_cfg_loader #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .MAX_DELAY(MD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_sel_delay(cfg_sel_delay), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_delay(cfg_delay), .busy(busy),
    .done(done), .clamp_err(clamp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    bit            sel;
    logic [`W-1:0] wdata;
    logic [7:0]    dly;
    bit            last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   we_cnt = 0;
  int   done_cnt = 0;
  // Model: 0 idle, 1 loading, 2 done cycle; k counts words accepted this run.
  int   mode = 0;
  int   k = 0;
  bit   m_clamp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word k of a run goes to synapse k mod NSYN; the first
  // NSYN words are weights, the next NSYN are delays saturated at MD-1.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mode = 0; k = 0; m_clamp = 1'b0;
        exp_q.delete();
      end else begin
        case (mode)
          0: if (start && !abort) begin mode = 1; k = 0; m_clamp = 1'b0; end
          1: begin
            if (abort) begin
              mode = 0; k = 0;
            end else if (s_valid) begin
              e.addr  = k % NSYN;
              e.sel   = (k >= NSYN);
              e.wdata = s_data;
              e.dly   = (int'(s_data) > MD - 1) ? 8'(MD - 1) : s_data[7:0];
              e.last  = (k == 2 * NSYN - 1);
              if (e.sel && int'(s_data) > MD - 1) m_clamp = 1'b1;
              exp_q.push_back(e);
              k++;
              if (k == 2 * NSYN) mode = 2;
            end
          end
          default: mode = 0;
        endcase
      end
    end
  end

  // Monitor: every write must appear exactly one cycle after its handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg_we) we_cnt++;
      if (done) done_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cfg_we", 32'(cfg_we), 32'd1);
        chk("cfg_addr", 32'(cfg_addr), 32'(e.addr));
        chk("cfg_sel_delay", 32'(cfg_sel_delay), 32'(e.sel));
        if (e.sel) chk("cfg_delay", 32'(cfg_delay), 32'(e.dly));
        else       chk("cfg_wdata", 32'(cfg_wdata), 32'(e.wdata));
        chk("done", 32'(done), 32'(e.last));
      end else begin
        chk("unexpected_we", 32'(cfg_we), 32'd0);
        chk("stray_done", 32'(done), 32'd0);
      end
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("s_ready", 32'(s_ready), 32'(mode == 1 && !abort));
      chk("clamp_err", 32'(clamp_err), 32'(m_clamp));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic send(input logic [`W-1:0] w, input int gap);
    repeat (gap) begin s_valid = 1'b0; s_data = `W'($urandom); cyc(); end
    s_valid = 1'b1; s_data = w; cyc(); s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({name, "_idle_timeout"}, 32'(i < 30), 32'd1);
    cyc();
  endtask

  logic [`W-1:0] base[8];

  initial begin
    int d0, w0;
    base[0] = `FX(0.30);  base[1] = `FX(0.10);
    base[2] = `FX(-0.05); base[3] = `FX(0.35);
    base[4] = 16'd1; base[5] = 16'd2; base[6] = 16'd3; base[7] = 16'd0;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_cfg_we", 32'(cfg_we), 32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();

    // Back-to-back nominal stream.
    d0 = done_cnt; w0 = we_cnt;
    do_start();
    for (int i = 0; i < 8; i++) send(base[i], 0);
    wait_idle("nominal");
    chk("nominal_writes", 32'(we_cnt - w0), 32'd8);
    chk("nominal_done", 32'(done_cnt - d0), 32'd1);

    // Same stream with valid on alternate cycles.
    d0 = done_cnt; w0 = we_cnt;
    do_start();
    for (int i = 0; i < 8; i++) send(base[i], 1);
    wait_idle("toggle");
    chk("toggle_writes", 32'(we_cnt - w0), 32'd8);
    chk("toggle_done", 32'(done_cnt - d0), 32'd1);

    // Out-of-range delay at synapse 2; flag must persist until next start.
    do_start();
    for (int i = 0; i < 8; i++) send((i == 6) ? 16'd12 : base[i], 0);
    wait_idle("clamp");
    repeat (3) cyc();
    chk("clamp_sticky", 32'(clamp_err), 32'd1);

    // Abort after three weights, with a word offered in the abort cycle.
    d0 = done_cnt; w0 = we_cnt;
    do_start();
    for (int i = 0; i < 3; i++) send(base[i], 0);
    abort = 1'b1; s_valid = 1'b1; s_data = base[3]; cyc();
    abort = 1'b0; s_valid = 1'b0;
    repeat (3) cyc();
    chk("abort_writes", 32'(we_cnt - w0), 32'd3);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    do_start();
    for (int i = 0; i < 8; i++) send(base[i], 0);
    wait_idle("restart");

    // Reset pulse during the delay phase.
    do_start();
    for (int i = 0; i < 5; i++) send(base[i], 0);
    s_valid = 1'b1; s_data = base[5];
    @(posedge clk); #2 rst_n = 1'b0; s_valid = 1'b0;
    #1;
    chk("midrst_cfg_we", 32'(cfg_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(cfg_addr), 32'd0);
    chk("midrst_delay", 32'(cfg_delay), 32'd0);
    chk("midrst_wdata", 32'(cfg_wdata), 32'd0);
    chk("midrst_sel", 32'(cfg_sel_delay), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) send(base[i], 0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Start and abort together in IDLE.
    start = 1'b1; abort = 1'b1; cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    repeat (2) cyc();

    // Randomized runs: random words, gaps, out-of-range delays and aborts.
    for (int r = 0; r < 12; r++) begin
      do_start();
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          abort = 1'b1; s_valid = 1'($urandom); cyc();
          abort = 1'b0; s_valid = 1'b0;
          break;
        end
        if (i < 4) send(`W'($urandom), int'($urandom_range(0, 2)));
        else if ($urandom_range(0, 3) == 0) send(`W'($urandom), int'($urandom_range(0, 2)));
        else send(`W'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end
      wait_idle("random");
    end

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
